// File: rtl/position_move_sequencer_pkg.sv
// ============================================================================
// Module   : position_move_sequencer_pkg
// Brief    : Shared state encoding and width helper for the move sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package position_move_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      MOVE   = 3'd2,
      SETTLE = 3'd3,
      FAULT  = 3'd4
   } seq_state_t;

   // Bits needed to hold 0..max_count, never less than one.
   function automatic int count_width(input longint unsigned max_count);
      return (max_count < 2) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/position_move_sequencer_pos_cmd_fifo.sv
// ============================================================================
// Module   : pos_cmd_fifo
// Brief    : Synchronous target FIFO with flush; push and pop may coincide.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pos_cmd_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     sys_clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign level   = count;
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/position_move_sequencer.sv
// ============================================================================
// Module   : position_move_sequencer
// Brief    : Queues target positions and feeds them one at a time to
//            position_control, tracking arrival, settle and timeout.
// Options  : POS_SEQ_LOOP_EN adds loop_en to replay the queued sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module position_move_sequencer
   import position_move_sequencer_pkg::*;
#(
   parameter int COUNTER_WIDTH  = 32,
   parameter int QUEUE_DEPTH    = 4,
   parameter int SETTLE_CYCLES  = 27_000,
   parameter int TIMEOUT_CYCLES = 54_000_000
) (
   input  logic                           sys_clk,
   input  logic                           reset_n,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [COUNTER_WIDTH-1:0]       cmd_target,
   input  logic                           abort,
`ifdef POS_SEQ_LOOP_EN
   input  logic                           loop_en,
`endif
   input  logic [COUNTER_WIDTH-1:0]       encoder_position,
   output logic                           pc_enable,
   output logic [COUNTER_WIDTH-1:0]       target_position,
   output logic                           busy,
   output logic                           done_pulse,
   output logic                           fault,
   output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
   output logic [15:0]                    move_count
);

   localparam int SETTLE_W  = count_width(SETTLE_CYCLES);
   localparam int TIMEOUT_W = count_width(TIMEOUT_CYCLES);

   seq_state_t                 state, state_nx;
   logic                       pc_enable_nx;
   logic [COUNTER_WIDTH-1:0]   target_nx;
   logic                       done_nx;
   logic                       fault_nx;
   logic [15:0]                move_count_nx;
   logic [SETTLE_W-1:0]        settle_cnt, settle_nx, settle_inc;
   logic [TIMEOUT_W-1:0]       timeout_cnt, timeout_nx, timeout_inc;
   logic                       at_target;
   logic                       settled;
   logic                       loop_hold;
   logic                       loop_push;
   logic                       host_push;
   logic                       fifo_pop;
   logic                       fifo_flush;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [COUNTER_WIDTH-1:0]   fifo_head;

`ifdef POS_SEQ_LOOP_EN
   assign loop_hold = loop_en;
`else
   assign loop_hold = 1'b0;
`endif

   assign busy      = (state != IDLE);
   assign cmd_ready = !fifo_full && !abort && (state != FAULT) && !(loop_hold && state != IDLE);
   assign host_push = cmd_valid && cmd_ready;

   pos_cmd_fifo #(
      .WIDTH (COUNTER_WIDTH),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .reset_n   (reset_n),
      .push      (host_push || loop_push),
      .push_data (loop_push ? target_position : cmd_target),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (queue_level)
   );

   assign at_target   = (encoder_position == target_position);
   // Arrival in MOVE counts as the first settle cycle.
   assign settle_inc  = (state != SETTLE) ? SETTLE_W'(1) :
                        (settle_cnt == SETTLE_W'(SETTLE_CYCLES)) ? settle_cnt : settle_cnt + SETTLE_W'(1);
   assign timeout_inc = (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES)) ? timeout_cnt : timeout_cnt + TIMEOUT_W'(1);
   assign settled     = at_target && (settle_inc >= SETTLE_W'(SETTLE_CYCLES));

   always_comb begin
      state_nx      = state;
      pc_enable_nx  = pc_enable;
      target_nx     = target_position;
      done_nx       = 1'b0;
      fault_nx      = fault;
      move_count_nx = move_count;
      settle_nx     = settle_cnt;
      timeout_nx    = timeout_cnt;
      fifo_pop      = 1'b0;
      fifo_flush    = 1'b0;
      loop_push     = 1'b0;

      case (state)
         IDLE: begin
            pc_enable_nx = 1'b0;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               target_nx  = fifo_head;
               settle_nx  = '0;
               timeout_nx = '0;
               state_nx   = LOAD;
            end
         end
         LOAD: begin
            pc_enable_nx = 1'b1;
            state_nx     = MOVE;
         end
         MOVE, SETTLE: begin
            timeout_nx = timeout_inc;
            settle_nx  = at_target ? settle_inc : '0;
            if (settled) begin
               done_nx       = 1'b1;
               move_count_nx = move_count + 16'd1;
               loop_push     = loop_hold;
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  target_nx  = fifo_head;
                  settle_nx  = '0;
                  timeout_nx = '0;
                  state_nx   = LOAD;
               end else begin
                  pc_enable_nx = 1'b0;
                  state_nx     = IDLE;
               end
            end else if (timeout_inc == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
               pc_enable_nx = 1'b0;
               fault_nx     = 1'b1;
               fifo_flush   = 1'b1;
               state_nx     = FAULT;
            end else begin
               state_nx = at_target ? SETTLE : MOVE;
            end
         end
         FAULT: begin
            pc_enable_nx = 1'b0;
            fault_nx     = 1'b1;
         end
         default: begin
            pc_enable_nx = 1'b0;
            state_nx     = IDLE;
         end
      endcase

      // Abort overrides everything decided above, including a pending completion.
      if (abort) begin
         state_nx      = IDLE;
         pc_enable_nx  = 1'b0;
         target_nx     = target_position;
         done_nx       = 1'b0;
         fault_nx      = 1'b0;
         move_count_nx = move_count;
         settle_nx     = '0;
         timeout_nx    = '0;
         fifo_pop      = 1'b0;
         fifo_flush    = 1'b1;
         loop_push     = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         pc_enable       <= 1'b0;
         target_position <= '0;
         done_pulse      <= 1'b0;
         fault           <= 1'b0;
         move_count      <= '0;
         settle_cnt      <= '0;
         timeout_cnt     <= '0;
      end else begin
         state           <= state_nx;
         pc_enable       <= pc_enable_nx;
         target_position <= target_nx;
         done_pulse      <= done_nx;
         fault           <= fault_nx;
         move_count      <= move_count_nx;
         settle_cnt      <= settle_nx;
         timeout_cnt     <= timeout_nx;
      end
   end

endmodule

`default_nettype wire
